// File: rtl/swervolf_sevseg_if.sv
// Wishbone slave bundle for the seven-segment scanner.
// Signal names keep the i_/o_ sense of the slave side so they read the same at both ends.
interface swervolf_sevseg_if;
  logic [4:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/swervolf_sevseg.sv
// Multiplexed seven-segment display controller with Wishbone register file,
// PWM brightness, per-digit blink and a hex / extended glyph font.

// Per-digit glyph decoder; outputs are active-low {a,b,c,d,e,f,g}.
module swervolf_sevseg_digit (
  input  logic [3:0] nib,
  input  logic       ext,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!ext) begin
      case (nib)
        4'h0: seg = 7'b0000001;
        4'h1: seg = 7'b1001111;
        4'h2: seg = 7'b0010010;
        4'h3: seg = 7'b0000110;
        4'h4: seg = 7'b1001100;
        4'h5: seg = 7'b0100100;
        4'h6: seg = 7'b0100000;
        4'h7: seg = 7'b0001111;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0001100;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b1100000;
        4'hC: seg = 7'b1110010;
        4'hD: seg = 7'b1000010;
        4'hE: seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end else begin
      // 0..6 light exactly one segment, a through g
      case (nib)
        4'h0: seg = 7'b0111111;
        4'h1: seg = 7'b1011111;
        4'h2: seg = 7'b1101111;
        4'h3: seg = 7'b1110111;
        4'h4: seg = 7'b1111011;
        4'h5: seg = 7'b1111101;
        4'h6: seg = 7'b1111110;
        4'h8: seg = 7'b1001000;
        4'h9: seg = 7'b1110001;
        4'hA: seg = 7'b1111010;
        4'hB: seg = 7'b1111001;
        4'hC: seg = 7'b1100011;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module swervolf_sevseg #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_LOG2 = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  swervolf_sevseg_if.slave    wb,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0]   enable_q, ext_q, bmask_q;
  logic [4*N_DIGITS-1:0] digits_q;
  logic [3:0]            bright_q;
  logic                  blink_q;
  logic                  ack_q;
  logic [31:0]           rdt_q;

  logic [REFRESH_LOG2-1:0] pre_q;
  logic [IW-1:0]           idx_q;
  logic [FW-1:0]           frm_q;
  logic                    phase_q;

  logic        acc, wr;
  logic [2:0]  rsel;
  logic [31:0] wmask, en_pad, ext_pad, bm_pad, ctrl_rd, rd_data;
  logic [31:0] en_wr, ext_wr, bm_wr;
  logic [63:0] dig_pad, dig_lo_wr, dig_hi_wr;

  assign acc  = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
  assign wr   = acc & wb.i_wb_we;
  assign rsel = wb.i_wb_adr[4:2];

  // Registers are widened to the bus/nibble map; merging here and truncating on
  // store drops bits of absent digits for free.
  always_comb begin
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{wb.i_wb_sel[b]}};
    en_pad  = '0; en_pad[N_DIGITS-1:0]    = enable_q;
    ext_pad = '0; ext_pad[N_DIGITS-1:0]   = ext_q;
    bm_pad  = '0; bm_pad[N_DIGITS-1:0]    = bmask_q;
    dig_pad = '0; dig_pad[4*N_DIGITS-1:0] = digits_q;
    ctrl_rd = {23'b0, blink_q, 4'b0, bright_q};
    en_wr   = (en_pad  & ~wmask) | (wb.i_wb_dat & wmask);
    ext_wr  = (ext_pad & ~wmask) | (wb.i_wb_dat & wmask);
    bm_wr   = (bm_pad  & ~wmask) | (wb.i_wb_dat & wmask);
    dig_lo_wr = {dig_pad[63:32], (dig_pad[31:0] & ~wmask) | (wb.i_wb_dat & wmask)};
    dig_hi_wr = {(dig_pad[63:32] & ~wmask) | (wb.i_wb_dat & wmask), dig_pad[31:0]};
  end

  always_comb begin
    rd_data = '0;
    case (rsel)
      3'd0: rd_data = en_pad;
      3'd1: rd_data = ext_pad;
      3'd2: rd_data = dig_pad[31:0];
      3'd3: rd_data = dig_pad[63:32];
      3'd4: rd_data = ctrl_rd;
      3'd5: rd_data = bm_pad;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      enable_q <= '0;
      ext_q    <= '0;
      bmask_q  <= '0;
      digits_q <= '0;
      bright_q <= '0;
      blink_q  <= 1'b0;
    end else if (wr) begin
      case (rsel)
        3'd0: enable_q <= en_wr[N_DIGITS-1:0];
        3'd1: ext_q    <= ext_wr[N_DIGITS-1:0];
        3'd2: digits_q <= dig_lo_wr[4*N_DIGITS-1:0];
        3'd3: digits_q <= dig_hi_wr[4*N_DIGITS-1:0];
        3'd4: begin
          if (wb.i_wb_sel[0]) bright_q <= wb.i_wb_dat[3:0];
          if (wb.i_wb_sel[1]) blink_q  <= wb.i_wb_dat[8];
        end
        3'd5: bmask_q  <= bm_wr[N_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= acc;
      if (acc) rdt_q <= rd_data;
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;

  // Scan timebase runs independently of the bus so writes never shift the refresh.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q <= pre_q + REFRESH_LOG2'(1);
      if (&pre_q) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          if (frm_q == FRM_LAST) begin
            frm_q   <= '0;
            phase_q <= ~phase_q;
          end else begin
            frm_q <= frm_q + FW'(1);
          end
        end
      end
    end
  end

  logic [N_DIGITS-1:0][6:0] seg_all;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    swervolf_sevseg_digit u_digit (
      .nib (digits_q[4*g +: 4]),
      .ext (ext_q[g]),
      .seg (seg_all[g])
    );
  end

  logic [3:0]          duty;
  logic                lit;
  logic [N_DIGITS-1:0] an_nxt;

  // Top prescaler nibble is the PWM ramp: brightness 15 is always on, 0 is one sixteenth.
  assign duty = pre_q[REFRESH_LOG2-1 -: 4];
  assign lit  = enable_q[idx_q] & (duty <= bright_q) & ~(blink_q & bmask_q[idx_q] & phase_q);

  always_comb begin
    an_nxt = '1;
    if (lit) an_nxt[idx_q] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
    end else begin
      o_an  <= an_nxt;
      o_seg <= lit ? seg_all[idx_q] : 7'h7F;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wb.i_wb_adr[1:0], en_wr, ext_wr, bm_wr, dig_lo_wr, dig_hi_wr};
endmodule

// File: tb/tb_swervolf_sevseg.sv
// Scoreboarded bench for swervolf_sevseg: bus reads checked from a queue on ack,
// display checked every cycle against a time-based model of the scan.
module tb_swervolf_sevseg;
  localparam int N = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  swervolf_sevseg_if wb();
  logic [N-1:0] o_an;
  logic [6:0]   o_seg;

  swervolf_sevseg #(.N_DIGITS(N), .REFRESH_LOG2(4), .BLINK_FRAMES(2)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .wb    (wb.slave),
    .o_an  (o_an),
    .o_seg (o_seg)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    int          reg_no;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m_reg [8];
  logic [31:0] s_reg [8];
  logic [6:0] font_hex [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                               7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0] font_ext [16] = '{7'b0111111, 7'b1011111, 7'b1101111, 7'b1110111,
                               7'b1111011, 7'b1111101, 7'b1111110, 7'b1111111,
                               7'b1001000, 7'b1110001, 7'b1111010, 7'b1111001,
                               7'b1100011, 7'b1111111, 7'b1111111, 7'b1111111};

  function automatic logic [31:0] valid_mask(input int r);
    case (r)
      0, 1, 5: return 32'h0000_00FF;
      2:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_010F;
      default: return 32'h0;
    endcase
  endfunction

  // Cycles since the last reset edge; the display is a pure function of this and the registers.
  int k;
  bit started = 1'b0;
  always @(posedge i_clk) begin
    if (i_rst) begin
      k <= 0;
      started <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge i_clk) begin : disp_mon
    int s, pre, idx, frame, dig;
    bit phase, lit, ext;
    logic [7:0] ean;
    logic [6:0] eseg;
    if (started) begin
      ean = 8'hFF;
      eseg = 7'h7F;
      if (k > 0) begin
        s = k - 1;
        pre = s % 16;
        idx = (s / 16) % N;
        frame = s / (16 * N);
        phase = ((frame / 2) % 2) == 1;
        lit = s_reg[0][idx] && (pre <= int'(s_reg[4][3:0])) &&
              !(s_reg[4][8] && s_reg[5][idx] && phase);
        dig = int'((s_reg[2] >> (4 * idx)) & 32'hF);
        ext = s_reg[1][idx];
        if (lit) begin
          ean = ~(8'd1 << idx);
          eseg = ext ? font_ext[dig] : font_hex[dig];
        end
      end
      checks++;
      if (o_an !== ean || o_seg !== eseg) begin
        errors++;
        $display("FAIL display k=%0d an=%h want %h seg=%b want %b", k, o_an, ean, o_seg, eseg);
      end
      for (int i = 0; i < 8; i++) s_reg[i] = m_reg[i];
    end
  end

  always @(negedge i_clk) begin : bus_mon
    exp_t e;
    if (started && wb.o_wb_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack rdt=%h", wb.o_wb_rdt);
      end else begin
        e = sbq.pop_front();
        if (e.is_read) begin
          checks++;
          if (wb.o_wb_rdt !== e.exp) begin
            errors++;
            $display("FAIL read reg%0d got %h want %h", e.reg_no, wb.o_wb_rdt, e.exp);
          end
        end
      end
    end
  end

  task automatic wait_ack(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 4 && !ok) begin
      @(posedge i_clk); #1;
      n++;
      if (wb.o_wb_ack === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || n != 1) begin
      errors++;
      $display("FAIL ack_latency got %0d want 1", ok ? n : -1);
    end
  endtask

  task automatic bus_idle();
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
  endtask

  task automatic wb_write(input int r, input logic [31:0] d, input logic [3:0] sel);
    bit ok;
    logic [31:0] m;
    @(negedge i_clk);
    wb.i_wb_adr = 5'(r << 2);
    wb.i_wb_dat = d;
    wb.i_wb_sel = sel;
    wb.i_wb_we  = 1'b1;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    sbq.push_back('{1'b0, 32'h0, r});
    wait_ack(ok);
    if (ok) begin
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
      m_reg[r] = ((m_reg[r] & ~m) | (d & m)) & valid_mask(r);
    end else begin
      void'(sbq.pop_back());
    end
    @(negedge i_clk);
    bus_idle();
  endtask

  task automatic wb_read(input int r);
    bit ok;
    @(negedge i_clk);
    wb.i_wb_adr = 5'(r << 2);
    wb.i_wb_sel = 4'hF;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    sbq.push_back('{1'b1, m_reg[r], r});
    wait_ack(ok);
    if (!ok) void'(sbq.pop_back());
    @(negedge i_clk);
    bus_idle();
  endtask

  // Strobe held high: ack must alternate and each ack carries the register value.
  task automatic burst_read(input int r, input int n);
    @(negedge i_clk);
    wb.i_wb_adr = 5'(r << 2);
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    for (int j = 0; j < (n + 1) / 2; j++) sbq.push_back('{1'b1, m_reg[r], r});
    for (int j = 1; j <= n; j++) begin
      @(posedge i_clk); #1;
      checks++;
      if (wb.o_wb_ack !== 1'((j % 2) == 1)) begin
        errors++;
        $display("FAIL burst_ack edge %0d got %b want %b", j, wb.o_wb_ack, (j % 2) == 1);
      end
    end
    @(negedge i_clk);
    bus_idle();
  endtask

  task automatic do_reset(input bit with_write);
    @(negedge i_clk);
    i_rst = 1'b1;
    if (with_write) begin
      wb.i_wb_adr = 5'h00;
      wb.i_wb_dat = 32'hFF;
      wb.i_wb_sel = 4'hF;
      wb.i_wb_we  = 1'b1;
      wb.i_wb_cyc = 1'b1;
      wb.i_wb_stb = 1'b1;
    end
    @(posedge i_clk); #1;
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    sbq.delete();
    checks++;
    if (wb.o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b want 0", wb.o_wb_ack);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    bus_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 32'h0;
      s_reg[i] = 32'h0;
    end
    wb.i_wb_adr = '0;
    wb.i_wb_dat = '0;
    wb.i_wb_sel = '0;
    bus_idle();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int r = 0; r < 8; r++) wb_read(r);

    wb_write(0, 32'hFF, 4'hF);
    wb_write(2, 32'h7654_3210, 4'hF);
    wb_write(4, 32'h0000_000F, 4'hF);
    idle(300);
    for (int r = 0; r < 8; r++) wb_read(r);

    wb_write(1, 32'h01, 4'hF);
    wb_write(2, 32'h7654_3218, 4'h1);
    idle(150);

    wb_write(4, 32'h3, 4'hF);
    cnt = 0;
    repeat (128) begin
      @(negedge i_clk);
      if (o_an != 8'hFF) cnt++;
    end
    checks++;
    if (cnt != 32) begin
      errors++;
      $display("FAIL duty_count got %0d want 32", cnt);
    end

    wb_write(4, 32'h10F, 4'h3);
    wb_write(5, 32'h02, 4'hF);
    idle(1100);

    wb_write(0, 32'h0, 4'h0);
    wb_read(0);
    burst_read(0, 6);
    idle(37);
    do_reset(1'b1);
    for (int r = 0; r < 6; r++) wb_read(r);

    for (int it = 0; it < 250; it++) begin
      int r;
      logic [3:0] sel;
      r = $urandom_range(7, 0);
      sel = ($urandom_range(3, 0) == 0) ? 4'hF : 4'($urandom_range(15, 0));
      if ($urandom_range(2, 0) != 0) wb_write(r, $urandom, sel);
      else wb_read(r);
      idle($urandom_range(20, 0));
      if (it == 120) do_reset(1'b0);
    end
    idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
